// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: default depth, entry layout
// and the word-address slice that matches data-memory indexing.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_PTR_W = $clog2(SB_DEPTH);

  // Word compare slice; must track the DM row decode.
  localparam int unsigned WORD_LO = 2;
  localparam int unsigned WORD_HI = 15;
  localparam int unsigned WORD_W  = WORD_HI - WORD_LO + 1;

  // Field names avoid the 'byte' keyword; they map to st_byte/st_half.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_byte;
    logic        is_half;
    logic [31:0] pc;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of the store-buffer-facing signals: memory-stage store request, DM write
// port, load hazard query and occupancy status.
interface store_buffer_if #(
  parameter int unsigned DEPTH = store_buffer_pkg::SB_DEPTH
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             st_valid;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             st_byte;
  logic             st_half;
  logic [31:0]      st_pc;
  logic             st_ready;

  logic             dm_free;
  logic             dm_we;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_data;
  logic             dm_byte;
  logic             dm_half;
  logic [31:0]      dm_pc;

  logic [31:0]      ld_addr;
  logic             ld_check;
  logic             ld_hit;

  logic             sb_empty;
  logic [PTR_W:0]   sb_count;

  // Pipeline / memory side.
  modport master (
    output st_valid, st_addr, st_data, st_byte, st_half, st_pc,
    output dm_free, ld_addr, ld_check,
    input  st_ready, dm_we, dm_addr, dm_data, dm_byte, dm_half, dm_pc,
    input  ld_hit, sb_empty, sb_count
  );

  // Store buffer side.
  modport slave (
    input  st_valid, st_addr, st_data, st_byte, st_half, st_pc,
    input  dm_free, ld_addr, ld_check,
    output st_ready, dm_we, dm_addr, dm_data, dm_byte, dm_half, dm_pc,
    output ld_hit, sb_empty, sb_count
  );

endinterface

// File: rtl/sb_hit_cmp.sv
// Load-hazard detector: builds the valid mask of occupied slots from rp/cnt and
// compares each valid entry's word address against the load's.
module sb_hit_cmp
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic [WORD_W-1:0]          entry_word [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   rp,
  input  logic [$clog2(DEPTH):0]     cnt,
  input  logic [WORD_W-1:0]          ld_word,
  input  logic                       ld_check,
  output logic                       ld_hit
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] off;
    // Distance from head, modulo DEPTH via pointer-width truncation.
    assign off      = PTR_W'(i) - rp;
    assign valid[i] = ({1'b0, off} < cnt);
    assign match[i] = valid[i] && (entry_word[i] == ld_word);
  end

  assign ld_hit = ld_check && (|match);

endmodule

// File: rtl/store_buffer.sv
// In-order FIFO of committed stores feeding the DM write port; retires the head
// whenever DM is idle and flags loads that alias a pending store.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave sb
);
  localparam int unsigned    PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  sb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q;
  logic [PTR_W-1:0] rp_q;
  logic [PTR_W:0]   cnt_q;
  logic [PTR_W:0]   cnt_d;
  logic             push;
  logic             pop;
  logic             not_empty;
  sb_entry_t        head;
  sb_entry_t        st_entry;

  assign not_empty   = (cnt_q != '0);
  assign sb.st_ready = (cnt_q != CNT_FULL);
  assign push        = sb.st_valid && sb.st_ready;
  // Reset suppresses the write so discarded stores never reach DM.
  assign pop         = not_empty && sb.dm_free && !reset;

  assign st_entry = '{addr:    sb.st_addr,
                      data:    sb.st_data,
                      is_byte: sb.st_byte,
                      is_half: sb.st_half,
                      pc:      sb.st_pc};

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= st_entry;
        wp_q        <= wp_q + PTR_W'(1);
      end
      if (pop) begin
        rp_q <= rp_q + PTR_W'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    head = '0;
    if (not_empty) begin
      head = mem_q[rp_q];
    end
  end

  assign sb.dm_we    = pop;
  assign sb.dm_addr  = head.addr;
  assign sb.dm_data  = head.data;
  assign sb.dm_byte  = head.is_byte;
  assign sb.dm_half  = head.is_half;
  assign sb.dm_pc    = head.pc;
  assign sb.sb_empty = !not_empty;
  assign sb.sb_count = cnt_q;

  logic [WORD_W-1:0] entry_word [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign entry_word[i] = mem_q[i].addr[WORD_HI:WORD_LO];
  end

  logic unused_ld_bits;
  assign unused_ld_bits = ^{sb.ld_addr[31:WORD_HI+1], sb.ld_addr[WORD_LO-1:0]};

  sb_hit_cmp #(
    .DEPTH (DEPTH)
  ) u_hit_cmp (
    .entry_word (entry_word),
    .rp         (rp_q),
    .cnt        (cnt_q),
    .ld_word    (sb.ld_addr[WORD_HI:WORD_LO]),
    .ld_check   (sb.ld_check),
    .ld_hit     (sb.ld_hit)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, single store, fill/drain, wrap with
// concurrent push/pop, load hazard and mid-operation reset.
module tb_store_buffer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  store_buffer_if #(.DEPTH(4)) sb_if ();

  store_buffer #(
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow one unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sb_if.st_valid = 1'b0;
    sb_if.st_addr  = '0;
    sb_if.st_data  = '0;
    sb_if.st_byte  = 1'b0;
    sb_if.st_half  = 1'b0;
    sb_if.st_pc    = '0;
    sb_if.dm_free  = 1'b0;
    sb_if.ld_addr  = '0;
    sb_if.ld_check = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb_if.ld_check = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (sb_if.st_ready !== 1'b1) begin
        errors++; $display("FAIL reset_st_ready cyc %0d got %b exp 1", c, sb_if.st_ready);
      end
      checks++;
      if (sb_if.dm_we !== 1'b0) begin
        errors++; $display("FAIL reset_dm_we cyc %0d got %b exp 0", c, sb_if.dm_we);
      end
      checks++;
      if (sb_if.dm_addr !== 32'h0) begin
        errors++; $display("FAIL reset_dm_addr cyc %0d got %h exp 0", c, sb_if.dm_addr);
      end
      checks++;
      if (sb_if.ld_hit !== 1'b0) begin
        errors++; $display("FAIL reset_ld_hit cyc %0d got %b exp 0", c, sb_if.ld_hit);
      end
      checks++;
      if (sb_if.sb_count !== 3'd0 || sb_if.sb_empty !== 1'b1) begin
        errors++; $display("FAIL reset_count cyc %0d got %0d/%b exp 0/1", c,
                           sb_if.sb_count, sb_if.sb_empty);
      end
      tick();
    end
    sb_if.ld_check = 1'b0;
  endtask

  task automatic test_single();
    sb_if.dm_free  = 1'b1;
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = 32'h0000_0010;
    sb_if.st_data  = 32'hDEAD_BEEF;
    sb_if.st_pc    = 32'h0000_0100;
    #1;
    checks++;
    if (sb_if.dm_we !== 1'b0) begin
      errors++; $display("FAIL single_no_bypass got %b exp 0", sb_if.dm_we);
    end
    tick();
    sb_if.st_valid = 1'b0;
    #1;
    checks++;
    if (sb_if.dm_we !== 1'b1 || sb_if.dm_addr !== 32'h10 || sb_if.dm_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_drain got we=%b a=%h d=%h exp we=1 a=10 d=deadbeef",
                         sb_if.dm_we, sb_if.dm_addr, sb_if.dm_data);
    end
    checks++;
    if (sb_if.dm_pc !== 32'h100 || sb_if.dm_byte !== 1'b0 || sb_if.dm_half !== 1'b0 ||
        sb_if.sb_count !== 3'd1) begin
      errors++; $display("FAIL single_meta got pc=%h b=%b h=%b cnt=%0d exp 100/0/0/1",
                         sb_if.dm_pc, sb_if.dm_byte, sb_if.dm_half, sb_if.sb_count);
    end
    tick();
    #1;
    checks++;
    if (sb_if.sb_empty !== 1'b1 || sb_if.dm_we !== 1'b0) begin
      errors++; $display("FAIL single_empty got empty=%b we=%b exp 1/0",
                         sb_if.sb_empty, sb_if.dm_we);
    end
  endtask

  task automatic test_fill();
    sb_if.dm_free = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb_if.st_valid = 1'b1;
      sb_if.st_addr  = 32'(4 * i);
      sb_if.st_data  = 32'hA0 + 32'(i);
      sb_if.st_byte  = (i == 1);
      sb_if.st_half  = (i == 2);
      sb_if.st_pc    = 32'h400 + 32'(4 * i);
      tick();
    end
    sb_if.st_addr = 32'h40;
    sb_if.st_data = 32'hFF;
    sb_if.st_byte = 1'b0;
    sb_if.st_half = 1'b0;
    #1;
    checks++;
    if (sb_if.st_ready !== 1'b0 || sb_if.sb_count !== 3'd4) begin
      errors++; $display("FAIL fill_full got ready=%b cnt=%0d exp 0/4",
                         sb_if.st_ready, sb_if.sb_count);
    end
    tick();
    sb_if.st_valid = 1'b0;
    #1;
    checks++;
    if (sb_if.sb_count !== 3'd4) begin
      errors++; $display("FAIL fill_drop got cnt=%0d exp 4", sb_if.sb_count);
    end
    sb_if.dm_free = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (sb_if.dm_we !== 1'b1 || sb_if.dm_addr !== 32'(4 * i) ||
          sb_if.dm_data !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL fill_drain[%0d] got we=%b a=%h d=%h exp 1/%h/%h", i,
                           sb_if.dm_we, sb_if.dm_addr, sb_if.dm_data, 4 * i, 32'hA0 + i);
      end
      checks++;
      if (sb_if.dm_byte !== (i == 1) || sb_if.dm_half !== (i == 2) ||
          sb_if.dm_pc !== 32'h400 + 32'(4 * i)) begin
        errors++; $display("FAIL fill_size[%0d] got b=%b h=%b pc=%h", i,
                           sb_if.dm_byte, sb_if.dm_half, sb_if.dm_pc);
      end
      checks++;
      if (sb_if.st_ready !== (i != 0)) begin
        errors++; $display("FAIL fill_ready[%0d] got %b exp %b", i, sb_if.st_ready, i != 0);
      end
      tick();
    end
    #1;
    checks++;
    if (sb_if.sb_empty !== 1'b1 || sb_if.dm_we !== 1'b0) begin
      errors++; $display("FAIL fill_after got empty=%b we=%b exp 1/0",
                         sb_if.sb_empty, sb_if.dm_we);
    end
  endtask

  task automatic test_back_to_back();
    sb_if.dm_free = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sb_if.st_valid = 1'b1;
      sb_if.st_addr  = 32'h200 + 32'(4 * k);
      sb_if.st_data  = 32'(k);
      #1;
      checks++;
      if (sb_if.sb_count !== ((k == 0) ? 3'd0 : 3'd1)) begin
        errors++; $display("FAIL b2b_count[%0d] got %0d exp %0d", k, sb_if.sb_count, k != 0);
      end
      if (k > 0) begin
        checks++;
        if (sb_if.dm_we !== 1'b1 || sb_if.dm_addr !== 32'h200 + 32'(4 * (k - 1))) begin
          errors++; $display("FAIL b2b_addr[%0d] got we=%b a=%h exp 1/%h", k,
                             sb_if.dm_we, sb_if.dm_addr, 32'h200 + 4 * (k - 1));
        end
      end
      tick();
    end
    sb_if.st_valid = 1'b0;
    #1;
    checks++;
    if (sb_if.dm_we !== 1'b1 || sb_if.dm_addr !== 32'h224 || sb_if.sb_count !== 3'd1) begin
      errors++; $display("FAIL b2b_last got we=%b a=%h cnt=%0d exp 1/224/1",
                         sb_if.dm_we, sb_if.dm_addr, sb_if.sb_count);
    end
    tick();
    #1;
    checks++;
    if (sb_if.sb_empty !== 1'b1) begin
      errors++; $display("FAIL b2b_empty got %b exp 1", sb_if.sb_empty);
    end
  endtask

  task automatic test_hazard();
    sb_if.dm_free  = 1'b0;
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = 32'h0000_1003;
    sb_if.st_data  = 32'h5A;
    sb_if.st_byte  = 1'b1;
    sb_if.ld_check = 1'b1;
    sb_if.ld_addr  = 32'h0000_1000;
    #1;
    checks++;
    if (sb_if.ld_hit !== 1'b0) begin
      errors++; $display("FAIL hz_push_same_cycle got %b exp 0", sb_if.ld_hit);
    end
    tick();
    sb_if.st_valid = 1'b0;
    sb_if.st_byte  = 1'b0;
    #1;
    checks++;
    if (sb_if.ld_hit !== 1'b1) begin
      errors++; $display("FAIL hz_hit_1000 got %b exp 1", sb_if.ld_hit);
    end
    sb_if.ld_addr = 32'h0000_1004;
    #1;
    checks++;
    if (sb_if.ld_hit !== 1'b0) begin
      errors++; $display("FAIL hz_miss_1004 got %b exp 0", sb_if.ld_hit);
    end
    sb_if.ld_addr  = 32'h0000_1000;
    sb_if.ld_check = 1'b0;
    #1;
    checks++;
    if (sb_if.ld_hit !== 1'b0) begin
      errors++; $display("FAIL hz_no_check got %b exp 0", sb_if.ld_hit);
    end
    sb_if.ld_check = 1'b1;
    sb_if.dm_free  = 1'b1;
    #1;
    checks++;
    if (sb_if.ld_hit !== 1'b1 || sb_if.dm_we !== 1'b1 || sb_if.dm_byte !== 1'b1) begin
      errors++; $display("FAIL hz_popping got hit=%b we=%b b=%b exp 1/1/1",
                         sb_if.ld_hit, sb_if.dm_we, sb_if.dm_byte);
    end
    tick();
    #1;
    checks++;
    if (sb_if.ld_hit !== 1'b0 || sb_if.sb_empty !== 1'b1) begin
      errors++; $display("FAIL hz_drained got hit=%b empty=%b exp 0/1",
                         sb_if.ld_hit, sb_if.sb_empty);
    end
    sb_if.ld_check = 1'b0;
  endtask

  task automatic test_reset_mid();
    sb_if.dm_free = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_if.st_valid = 1'b1;
      sb_if.st_addr  = 32'h300 + 32'(4 * i);
      tick();
    end
    sb_if.st_valid = 1'b0;
    #1;
    checks++;
    if (sb_if.sb_count !== 3'd3) begin
      errors++; $display("FAIL rm_pending got %0d exp 3", sb_if.sb_count);
    end
    reset         = 1'b1;
    sb_if.dm_free = 1'b1;
    #1;
    checks++;
    if (sb_if.dm_we !== 1'b0) begin
      errors++; $display("FAIL rm_we_in_reset got %b exp 0", sb_if.dm_we);
    end
    tick();
    reset          = 1'b0;
    sb_if.ld_check = 1'b1;
    sb_if.ld_addr  = 32'h300;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (sb_if.dm_we !== 1'b0 || sb_if.sb_count !== 3'd0 || sb_if.st_ready !== 1'b1) begin
        errors++; $display("FAIL rm_after[%0d] got we=%b cnt=%0d ready=%b exp 0/0/1", c,
                           sb_if.dm_we, sb_if.sb_count, sb_if.st_ready);
      end
      checks++;
      if (sb_if.ld_hit !== 1'b0 || sb_if.dm_addr !== 32'h0) begin
        errors++; $display("FAIL rm_stale[%0d] got hit=%b a=%h exp 0/0", c,
                           sb_if.ld_hit, sb_if.dm_addr);
      end
      tick();
    end
    sb_if.ld_check = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_hazard();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order FIFO of committed stores, directly upstream of the data memory (DM) write port.
- Accepts one store per cycle from the memory stage and retires the oldest pending store into DM whenever the DM port is idle.
- Reports pending-store hits on a word address so the hazard unit can stall a dependent load until that store has drained.
- Word indexing matches DM: entries and loads are compared on address bits [15:2].

Parameters:
- DEPTH, 4, number of buffered stores; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- st_valid  input  1  store request from the memory stage.
- st_addr  input  32  store byte address.
- st_data  input  32  store data, unshifted, LSB-aligned.
- st_byte  input  1  byte store (sb).
- st_half  input  1  halfword store (sh); ignored when st_byte=1.
- st_pc  input  32  PC of the store, carried for the DM trace line.
- st_ready  output  1  buffer can accept a store this cycle.
- dm_free  input  1  DM port is not used by a load this cycle.
- dm_we  output  1  write enable to DM.
- dm_addr  output  32  DM Address.
- dm_data  output  32  DM data.
- dm_byte  output  1  DM if_byte.
- dm_half  output  1  DM if_half.
- dm_pc  output  32  DM PC.
- ld_addr  input  32  address of the load in the memory stage.
- ld_check  input  1  a load is present in the memory stage.
- ld_hit  output  1  a pending entry has the same word address as ld_addr.
- sb_empty  output  1  no pending stores.
- sb_count  output  PTR_W+1  number of pending stores.

Behaviour:
- Storage is a circular FIFO with write pointer wp, read pointer rp and counter cnt. Each entry holds {addr, data, byte, half, pc}.
- Reset, taking priority over everything: wp=0, rp=0, cnt=0, entry contents don't-care. Immediately after reset: st_ready=1, dm_we=0, dm_* data outputs=0, ld_hit=0, sb_empty=1, sb_count=0.
- Reset asserted while stores are pending discards those stores; no DM write occurs in the reset cycle.
- st_ready = (cnt != DEPTH). It is registered-state-only and does not depend on a same-cycle pop.
- Push condition: st_valid && st_ready. At the edge, the entry is written at wp, wp increments modulo DEPTH and cnt increments.
- st_valid while full is ignored. The upstream stage must hold the store and stall.
- Drain is combinational from the head: dm_we = (cnt != 0) && dm_free. dm_addr, dm_data, dm_byte, dm_half and dm_pc are taken from entry rp when cnt != 0, and are 0 when empty.
- Pop condition: dm_we. At the edge, rp increments modulo DEPTH and cnt decrements.
- Latency: a store pushed into an empty buffer appears on dm_* in the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop: cnt is unchanged, both pointers advance. This is legal at any cnt from 1 to DEPTH-1. At cnt=DEPTH only the pop occurs, because st_ready=0.
- Pointers wrap from DEPTH-1 to 0. cnt never exceeds DEPTH and never underflows.
- ld_hit = ld_check && OR over the valid entries of (entry.addr[15:2] == ld_addr[15:2]).
  - An entry at slot i is valid when ((i - rp) mod DEPTH) < cnt.
  - A store being pushed in the same cycle is not included.
  - A store popping this cycle is still included, which gives a conservative one-cycle stall.
- Size flags pass through unchanged. Byte/half lane merging is performed by DM; this block does no shifting.
- sb_empty = (cnt == 0). sb_count = cnt.

Decomposition:
- Shared package store_buffer_pkg holds:
  - SB_DEPTH default and the derived pointer width;
  - the entry struct {addr[31:0], data[31:0], byte, half, pc[31:0]};
  - WORD_LO=2 and WORD_HI=15, the compare slice matching DM indexing.
- One sub-module, sb_hit_cmp: per-entry valid-mask generation plus word-address comparison, reducing to ld_hit. The FIFO control stays in the top module.

Test Plan:
- Reset then idle -> st_ready=1, dm_we=0, dm_addr=0, ld_hit=0, sb_count=0 for 3 cycles.
- Single store: push st_addr=0x0000_0010, st_data=0xDEAD_BEEF, word size, dm_free=1 -> next cycle dm_we=1, dm_addr=0x10, dm_data=0xDEADBEEF; the cycle after, sb_empty=1.
- Fill with dm_free=0: push 4 stores (0x0, 0x4, 0x8, 0xC) -> st_ready=0 and sb_count=4. A 5th st_valid is dropped. Raising dm_free then drains all four in order, with st_ready=1 again after the first pop.
- Wrap and simultaneous push/pop: keep dm_free=1 and push every cycle for 10 cycles -> sb_count stays 1 after the first cycle, and DM sees all 10 addresses in order across a pointer wrap.
- Load hazard:
  - pending sb at 0x0000_1003 with ld_check=1, ld_addr=0x0000_1000 -> ld_hit=1;
  - ld_addr=0x0000_1004 -> ld_hit=0;
  - after that entry drains -> ld_hit=0 for 0x1000.
- Reset mid-operation: 3 pending stores, assert reset for one cycle -> no dm_we in or after the reset cycle, sb_count=0, st_ready=1.
